// File: rtl/dmem_mmio.sv
// Data-side memory stage for the single-cycle tinymips core: word RAM plus an
// I/O page (LED/HEX outputs, synchronised SW/KEY, sticky key edges, cycle counter).
module dmem_mmio #(
  parameter int DMEM_WORDS = 64,
  parameter int SW_W       = 10,
  parameter int KEY_W      = 4,
  parameter int LED_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key,
  output logic [LED_W-1:0] led,
  output logic [23:0]      hex,
  output logic             bus_err
);

  localparam int N = $clog2(DMEM_WORDS);

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_HEX   = 8'h04;
  localparam logic [7:0] OFF_SW    = 8'h08;
  localparam logic [7:0] OFF_KEY   = 8'h0C;
  localparam logic [7:0] OFF_KEDGE = 8'h10;
  localparam logic [7:0] OFF_CYC   = 8'h14;

  logic [31:0]      mem_q [DMEM_WORDS];

  logic [LED_W-1:0] led_q,     led_d;
  logic [23:0]      hex_q,     hex_d;
  logic [SW_W-1:0]  sw_s1_q,   sw_s2_q;
  logic [KEY_W-1:0] key_s1_q,  key_s2_q, key_d_q;
  logic [KEY_W-1:0] kedge_q,   kedge_d;
  logic [31:0]      cycles_q,  cycles_d;
  logic             bus_err_q, bus_err_d;

  logic             ram_hit_s;
  logic             io_hit_s;
  logic             io_valid_s;
  logic             unmapped_s;
  logic [N-1:0]     ram_idx_s;
  logic [7:0]       io_off_s;
  logic             ram_we_s;
  logic             led_we_s;
  logic             hex_we_s;
  logic             kedge_we_s;
  logic             cyc_we_s;
  logic [KEY_W-1:0] kedge_clr_s;
  logic [KEY_W-1:0] kedge_new_s;
  logic [31:0]      rdata_s;
  logic             unused_addr_s;

  // Byte-lane bits are meaningless for word-only accesses.
  assign unused_addr_s = ^addr[1:0];

  always_comb begin
    ram_hit_s = (addr[31:N+2] == {(30-N){1'b0}});
    io_hit_s  = (addr[31:8] == 24'hFFFFFF);
    ram_idx_s = addr[N+1:2];
    io_off_s  = {addr[7:2], 2'b00};
    case (io_off_s)
      OFF_LED, OFF_HEX, OFF_SW, OFF_KEY, OFF_KEDGE, OFF_CYC: io_valid_s = 1'b1;
      default:                                              io_valid_s = 1'b0;
    endcase
    unmapped_s = !(ram_hit_s || (io_hit_s && io_valid_s));
  end

  always_comb begin
    ram_we_s   = memwrite && ram_hit_s;
    led_we_s   = memwrite && io_hit_s && (io_off_s == OFF_LED);
    hex_we_s   = memwrite && io_hit_s && (io_off_s == OFF_HEX);
    kedge_we_s = memwrite && io_hit_s && (io_off_s == OFF_KEDGE);
    cyc_we_s   = memwrite && io_hit_s && (io_off_s == OFF_CYC);
  end

  always_comb begin
    led_d     = led_q;
    hex_d     = hex_q;
    bus_err_d = bus_err_q;
    if (led_we_s) begin
      led_d = writedata[LED_W-1:0];
    end else begin
      led_d = led_q;
    end
    if (hex_we_s) begin
      hex_d = writedata[23:0];
    end else begin
      hex_d = hex_q;
    end
    if (memwrite && unmapped_s) begin
      bus_err_d = 1'b1;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // A fresh edge in the same cycle as a clear must survive, so OR it in last.
  always_comb begin
    kedge_new_s = key_s2_q & ~key_d_q;
    kedge_clr_s = {KEY_W{1'b0}};
    if (kedge_we_s) begin
      kedge_clr_s = writedata[KEY_W-1:0];
    end else begin
      kedge_clr_s = {KEY_W{1'b0}};
    end
    kedge_d = (kedge_q & ~kedge_clr_s) | kedge_new_s;
  end

  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (cyc_we_s) begin
      cycles_d = 32'h0000_0000;
    end else begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= {LED_W{1'b0}};
      hex_q     <= 24'h000000;
      sw_s1_q   <= {SW_W{1'b0}};
      sw_s2_q   <= {SW_W{1'b0}};
      key_s1_q  <= {KEY_W{1'b0}};
      key_s2_q  <= {KEY_W{1'b0}};
      key_d_q   <= {KEY_W{1'b0}};
      kedge_q   <= {KEY_W{1'b0}};
      cycles_q  <= 32'h0000_0000;
      bus_err_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      hex_q     <= hex_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      key_s1_q  <= key;
      key_s2_q  <= key_s1_q;
      key_d_q   <= key_s2_q;
      kedge_q   <= kedge_d;
      cycles_q  <= cycles_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_idx_s] <= writedata;
    end
  end

  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ram_hit_s) begin
      rdata_s = mem_q[ram_idx_s];
    end else if (io_hit_s) begin
      case (io_off_s)
        OFF_LED:   rdata_s = 32'(led_q);
        OFF_HEX:   rdata_s = {8'h00, hex_q};
        OFF_SW:    rdata_s = 32'(sw_s2_q);
        OFF_KEY:   rdata_s = 32'(key_s2_q);
        OFF_KEDGE: rdata_s = 32'(kedge_q);
        OFF_CYC:   rdata_s = cycles_q;
        default:   rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign readdata = rdata_s;
  assign led      = led_q;
  assign hex      = hex_q;
  assign bus_err  = bus_err_q;

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-side memory stage of the single-cycle tinymips core. Consumes the datapath's ALU result as address and store data, and returns load data in the same cycle. Decodes the address into a word-addressed data RAM and a small memory-mapped I/O page. The I/O page holds LED/HEX output registers, synchronised switch/key inputs, sticky key-edge capture and a free-running cycle counter.

Parameters:
DMEM_WORDS, 64, data RAM depth in 32-bit words (power of 2, 4..1024)
SW_W, 10, switch input width (1..32)
KEY_W, 4, push-button input width (1..32)
LED_W, 10, LED output register width (1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
memwrite  input  1  store enable for the current instruction
addr  input  32  byte address (datapath ALU result); addr[1:0] ignored
writedata  input  32  store data
readdata  output  32  load data, combinational from addr and current state
sw  input  SW_W  raw asynchronous switch levels
key  input  KEY_W  raw asynchronous button levels, active-high (1 = pressed)
led  output  LED_W  LED register
hex  output  24  six 4-bit hex digits for the display driver, digit 0 in [3:0]
bus_err  output  1  sticky flag: access to unmapped address

Behaviour:
- Address decode, word address A = addr with [1:0] cleared:
  - RAM: addr[31:N+2] all zero, where N = log2(DMEM_WORDS); index = addr[N+1:2].
  - IO page: addr[31:8] = 24'hFFFFFF; offset = addr[7:0].
  - Anything else, including unused IO offsets, is unmapped.
- IO offsets:
  - 0x00 LED: R/W; only [LED_W-1:0] stored; read zero-extended.
  - 0x04 HEX: R/W; [23:0] stored.
  - 0x08 SW: RO; synchronised switch value.
  - 0x0C KEY: RO; synchronised key level.
  - 0x10 KEY_EDGE: R/W1C; sticky rising-edge bits.
  - 0x14 CYCLES: R; a write of any data clears it.
  - Writes to RO offsets are ignored and do not set bus_err.
- Reads:
  - readdata is purely combinational from addr and register/RAM state; zero added latency, as required by the single-cycle core.
  - Unmapped reads return 0.
  - readdata is driven regardless of memwrite.
- Writes: take effect at the rising clk edge when memwrite=1 and are visible to reads from the following cycle. RAM write uses the full 32 bits; no byte enables.
- RAM: not reset; contents undefined until written. One write port, one asynchronous read port.
- Input synchronisers:
  - sw and key each pass through 2 flops; SW/KEY reads reflect pin changes 2 clk edges later.
  - A third key flop (key_d) provides edge detection. Edge bit i sets when key_sync[i]=1 and key_d[i]=0.
- KEY_EDGE write-1-to-clear: bits written 1 clear, bits written 0 are unchanged. If a new edge and a clear hit the same bit in the same cycle, the bit ends set (set wins).
- CYCLES: increments by 1 every clk edge and wraps 0xFFFFFFFF -> 0. On a write it loads 0 at that edge (not 1), then resumes counting.
- bus_err: set at the clk edge of any memwrite=1 access to an unmapped address. Unmapped reads do not set it. Cleared only by reset. Unmapped writes modify no state.
- Reset (rst=0, asynchronous):
  - led=0, hex=0, bus_err=0, CYCLES=0, KEY_EDGE=0, all synchroniser flops=0.
  - readdata follows decode; it reads 0 for every IO offset while rst is held.
  - Reset asserted mid-write: the write is lost; IO registers read 0 after release.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x00000004 and 0x12345678 to 0x000000FC (last word, DMEM_WORDS=64). Read both -> exact values; read 0x00000100 -> 0 and bus_err stays 0; write to 0x00000100 -> bus_err=1 and RAM word 0 unchanged.
- Write 0xFFFFFFFF to 0xFFFFFF00 -> led=10'h3FF and read 0x000003FF. Write 0x00ABCDEF to 0xFFFFFF04 -> hex=24'hABCDEF. Assert rst mid-run -> led=0 and hex=0 immediately, without waiting for clk.
- Set sw=10'h2A5 -> 0xFFFFFF08 reads 0 for 1 edge and 0x2A5 after the 2nd edge. Write 0xFFFFFFFF to 0xFFFFFF08 -> value unchanged, bus_err=0.
- Pulse key[2] high for 5 cycles -> KEY_EDGE=0x4 from edge 3, still 0x4 after release. Write 0x4 to 0xFFFFFF10 -> 0. Rising key[1] edge coincident with a W1C of 0x2 -> bit 1 reads 1.
- After reset, read CYCLES after 100 edges -> 100. Write to 0xFFFFFF14 -> reads 0 next cycle, 1 the cycle after. Force-load near 0xFFFFFFFF (bench force) -> wraps to 0.
- Write/read 0xFFFFFF20 and 0x80000000 -> reads 0 and bus_err=1. bus_err stays set through later legal accesses until rst=0.
